// File: rtl/decoder3to8_hold.sv
// Sequential 3-to-8 one-hot decoder with a one-deep pending slot, programmable hold and gap.
// Optional build macro DECODER_ACTIVE_LOW_EN makes d active-low (idle value 8'hFF).
module decoder3to8_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [2:0] code,
    output logic       code_ready,
    output logic [7:0] d,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic       HAS_GAP   = (GAP_CYCLES > 0);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] D_OFF = 8'hFF;
`else
    localparam logic [7:0] D_OFF = 8'h00;
`endif

    // XOR with the idle value yields the one-hot pattern in either polarity.
    function automatic logic [7:0] line_on(input logic [2:0] c);
        logic [7:0] oh;
        oh = 8'h01 << c;
        return oh ^ D_OFF;
    endfunction

    logic [1:0] state;
    logic [7:0] cnt;
    logic       pend_valid;
    logic [2:0] pend_code;
    logic       cnt_zero;
    logic       load;
    logic       accept;

    // Handshake: a code transfers on any edge where code_valid and code_ready are both high.
    // code_ready depends only on rst and registered state, so the slot may refill on the
    // same edge that its previous code is loaded into the output stage.
    always_comb begin
        cnt_zero   = (cnt == 8'd0);
        load       = pend_valid & ((state == IDLE) |
                                   ((state == GAP) & cnt_zero) |
                                   ((state == HOLD) & cnt_zero & ~HAS_GAP));
        code_ready = ~rst & (~pend_valid | load);
        accept     = code_valid & code_ready;
        busy       = (state != IDLE) | pend_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            d          <= D_OFF;
            done       <= 1'b0;
            pend_valid <= 1'b0;
            pend_code  <= 3'd0;
        end else begin
            done <= (state == HOLD) & cnt_zero;

            if (accept) begin
                pend_valid <= 1'b1;
                pend_code  <= code;
            end else if (load) begin
                pend_valid <= 1'b0;
            end

            if (load) begin
                d     <= line_on(pend_code);
                cnt   <= HOLD_LAST;
                state <= HOLD;
            end else begin
                case (state)
                    HOLD: begin
                        if (!cnt_zero) begin
                            cnt <= cnt - 8'd1;
                        end else if (HAS_GAP) begin
                            d     <= D_OFF;
                            cnt   <= GAP_LAST;
                            state <= GAP;
                        end else begin
                            d     <= D_OFF;
                            state <= IDLE;
                        end
                    end
                    GAP: begin
                        if (!cnt_zero) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        d     <= D_OFF;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder3to8_hold.sv
// Bench for decoder3to8_hold: two configurations (hold 4 / gap 1 and hold 1 / gap 0)
// checked against a timeline-queue reference model.
module tb_decoder3to8_hold;

    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int HOLD_B = 1;
    localparam int GAP_B  = 0;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] POL = 8'hFF;
`else
    localparam logic [7:0] POL = 8'h00;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic       cv    [2];
    logic [2:0] cd    [2];
    logic       cr    [2];
    logic [7:0] dv    [2];
    logic       bz    [2];
    logic       dn    [2];

    decoder3to8_hold #(.HOLD_CYCLES(HOLD_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst(rst_v[0]), .code_valid(cv[0]), .code(cd[0]),
        .code_ready(cr[0]), .d(dv[0]), .busy(bz[0]), .done(dn[0])
    );

    decoder3to8_hold #(.HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst(rst_v[1]), .code_valid(cv[1]), .code(cd[1]),
        .code_ready(cr[1]), .d(dv[1]), .busy(bz[1]), .done(dn[1])
    );

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds one entry per future output cycle: {last_hold_cycle, active-high d}.
    logic [8:0] exp_q [2][$];
    logic       m_pend [2] = '{1'b0, 1'b0};
    logic [2:0] m_code [2] = '{3'd0, 3'd0};
    logic [7:0] m_d    [2] = '{8'h00, 8'h00};
    logic       m_done [2] = '{1'b0, 1'b0};

    int n_vec = 0;
    int n_err = 0;

    function automatic int hold_of(input int i);
        return (i == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic logic exp_ready(input int i);
        return !rst_v[i] && (!m_pend[i] || exp_q[i].size() <= 1);
    endfunction

    function automatic logic exp_busy(input int i);
        return (exp_q[i].size() > 0) || m_pend[i];
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic       consume;
            logic       acc;
            logic [8:0] e;
            logic [7:0] oh;
            if (rst_v[i]) begin
                exp_q[i].delete();
                m_pend[i] = 1'b0;
                m_d[i]    = 8'h00;
                m_done[i] = 1'b0;
            end else begin
                consume   = m_pend[i] && (exp_q[i].size() <= 1);
                acc       = cv[i] && (!m_pend[i] || consume);
                m_done[i] = 1'b0;
                if (exp_q[i].size() > 0) begin
                    e         = exp_q[i].pop_front();
                    m_done[i] = e[8];
                end
                if (consume) begin
                    oh = 8'h01 << m_code[i];
                    for (int h = 0; h < hold_of(i); h++)
                        exp_q[i].push_back({(h == hold_of(i) - 1), oh});
                    for (int g = 0; g < gap_of(i); g++)
                        exp_q[i].push_back(9'h000);
                    m_pend[i] = 1'b0;
                end
                if (acc) begin
                    m_pend[i] = 1'b1;
                    m_code[i] = cd[i];
                end
                m_d[i] = (exp_q[i].size() > 0) ? exp_q[i][0][7:0] : 8'h00;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int i, input logic r, input logic v, input logic [2:0] c);
        rst_v[i] = r;
        cv[i]    = v;
        cd[i]    = c;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 1'b1, 1'b1, 3'd2);
        drive(1, 1'b1, 1'b1, 3'd2);
        next_cycle();
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (dv[i] !== POL) begin
                    n_err++; $display("FAIL reset d[%0d]: got %h exp %h", i, dv[i], POL);
                end
                n_vec++;
                if (cr[i] !== 1'b0) begin
                    n_err++; $display("FAIL reset code_ready[%0d]: got %b exp 0", i, cr[i]);
                end
                n_vec++;
                if (bz[i] !== 1'b0) begin
                    n_err++; $display("FAIL reset busy[%0d]: got %b exp 0", i, bz[i]);
                end
                n_vec++;
                if (dn[i] !== 1'b0) begin
                    n_err++; $display("FAIL reset done[%0d]: got %b exp 0", i, dn[i]);
                end
            end
            next_cycle();
        end
        drive(0, 1'b0, 1'b0, 3'd0);
        drive(1, 1'b0, 1'b0, 3'd0);
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (dv[i] !== POL || bz[i] !== 1'b0) begin
                    n_err++; $display("FAIL post_reset[%0d]: got d=%h busy=%b exp d=%h busy=0", i, dv[i], bz[i], POL);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        int on_cnt = 0;
        int done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, 1'b0, (c == 0), 3'd5);
            @(negedge clk);
            n_vec++;
            if (dv[0] !== (m_d[0] ^ POL)) begin
                n_err++; $display("FAIL single d: got %h exp %h at %0t", dv[0], m_d[0] ^ POL, $time);
            end
            n_vec++;
            if (dn[0] !== m_done[0] || bz[0] !== exp_busy(0) || cr[0] !== exp_ready(0)) begin
                n_err++; $display("FAIL single ctl: got done=%b busy=%b rdy=%b exp %b %b %b at %0t",
                                  dn[0], bz[0], cr[0], m_done[0], exp_busy(0), exp_ready(0), $time);
            end
            if (dv[0] === (8'h20 ^ POL)) on_cnt++;
            if (dn[0] === 1'b1) done_cnt++;
            next_cycle();
        end
        n_vec++;
        if (on_cnt != 4 || done_cnt != 1 || bz[0] !== 1'b0) begin
            n_err++; $display("FAIL single summary: got hold=%0d done=%0d busy=%b exp 4 1 0", on_cnt, done_cnt, bz[0]);
        end
    endtask

    task automatic test_back_to_back();
        int phase = 0;
        int n01 = 0;
        int n80 = 0;
        for (int c = 0; c < 16; c++) begin
            drive(0, 1'b0, (phase < 2), (phase == 0) ? 3'd0 : 3'd7);
            @(negedge clk);
            n_vec++;
            if (dv[0] !== (m_d[0] ^ POL)) begin
                n_err++; $display("FAIL b2b d: got %h exp %h at %0t", dv[0], m_d[0] ^ POL, $time);
            end
            n_vec++;
            if (cr[0] !== exp_ready(0) || dn[0] !== m_done[0] || bz[0] !== exp_busy(0)) begin
                n_err++; $display("FAIL b2b ctl: got rdy=%b done=%b busy=%b exp %b %b %b at %0t",
                                  cr[0], dn[0], bz[0], exp_ready(0), m_done[0], exp_busy(0), $time);
            end
            if (dv[0] === (8'h01 ^ POL)) n01++;
            if (dv[0] === (8'h80 ^ POL)) n80++;
            if (cv[0] && cr[0]) phase++;
            next_cycle();
        end
        n_vec++;
        if (n01 != 4 || n80 != 4 || phase != 2) begin
            n_err++; $display("FAIL b2b summary: got n01=%0d n80=%0d accepted=%0d exp 4 4 2", n01, n80, phase);
        end
    endtask

    task automatic test_no_gap();
        int j = 0;
        int dcnt = 0;
        int first = -1;
        int last = -1;
        logic [7:0] seq[$];
        for (int c = 0; c < 16; c++) begin
            drive(1, 1'b0, (j < 8), 3'(j));
            @(negedge clk);
            n_vec++;
            if (dv[1] !== (m_d[1] ^ POL)) begin
                n_err++; $display("FAIL nogap d: got %h exp %h at %0t", dv[1], m_d[1] ^ POL, $time);
            end
            n_vec++;
            if (cr[1] !== exp_ready(1) || dn[1] !== m_done[1] || bz[1] !== exp_busy(1)) begin
                n_err++; $display("FAIL nogap ctl: got rdy=%b done=%b busy=%b exp %b %b %b at %0t",
                                  cr[1], dn[1], bz[1], exp_ready(1), m_done[1], exp_busy(1), $time);
            end
            if (dv[1] !== POL) begin
                seq.push_back(dv[1] ^ POL);
                if (first < 0) first = c;
                last = c;
            end
            if (dn[1] === 1'b1) dcnt++;
            if (cv[1] && cr[1]) j++;
            next_cycle();
        end
        n_vec++;
        if (dcnt != 8 || seq.size() != 8 || (last - first) != 7) begin
            n_err++; $display("FAIL nogap summary: got done=%0d lines=%0d span=%0d exp 8 8 7", dcnt, seq.size(), last - first);
        end
        for (int k = 0; k < seq.size(); k++) begin
            n_vec++;
            if (seq[k] !== (8'h01 << k)) begin
                n_err++; $display("FAIL nogap step %0d: got %h exp %h", k, seq[k], 8'h01 << k);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n40 = 0;
        for (int c = 0; c < 14; c++) begin
            drive(0, (c == 4), (c < 2), (c == 0) ? 3'd3 : 3'd6);
            @(negedge clk);
            n_vec++;
            if (dv[0] !== (m_d[0] ^ POL) || bz[0] !== exp_busy(0) || cr[0] !== exp_ready(0)) begin
                n_err++; $display("FAIL midrst: got d=%h busy=%b rdy=%b exp %h %b %b at %0t",
                                  dv[0], bz[0], cr[0], m_d[0] ^ POL, exp_busy(0), exp_ready(0), $time);
            end
            if (c == 5) begin
                n_vec++;
                if (dv[0] !== POL || bz[0] !== 1'b0) begin
                    n_err++; $display("FAIL midrst after: got d=%h busy=%b exp %h 0", dv[0], bz[0], POL);
                end
            end
            if (dv[0] === (8'h40 ^ POL)) n40++;
            next_cycle();
        end
        n_vec++;
        if (n40 != 0) begin
            n_err++; $display("FAIL midrst code6: got %0d cycles exp 0", n40);
        end
    endtask

    task automatic test_ignored();
        int n02 = 0;
        int n04 = 0;
        int n10 = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 1'b0, (c < 3), (c == 0) ? 3'd1 : ((c == 1) ? 3'd2 : 3'd4));
            @(negedge clk);
            n_vec++;
            if (dv[0] !== (m_d[0] ^ POL) || cr[0] !== exp_ready(0) || dn[0] !== m_done[0]) begin
                n_err++; $display("FAIL ignored: got d=%h rdy=%b done=%b exp %h %b %b at %0t",
                                  dv[0], cr[0], dn[0], m_d[0] ^ POL, exp_ready(0), m_done[0], $time);
            end
            if (dv[0] === (8'h02 ^ POL)) n02++;
            if (dv[0] === (8'h04 ^ POL)) n04++;
            if (dv[0] === (8'h10 ^ POL)) n10++;
            next_cycle();
        end
        n_vec++;
        if (n02 != 4 || n04 != 4 || n10 != 0) begin
            n_err++; $display("FAIL ignored summary: got n02=%0d n04=%0d n10=%0d exp 4 4 0", n02, n04, n10);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++)
                drive(i, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)));
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (dv[i] !== (m_d[i] ^ POL)) begin
                    n_err++; $display("FAIL random d[%0d]: got %h exp %h at %0t", i, dv[i], m_d[i] ^ POL, $time);
                end
                n_vec++;
                if (cr[i] !== exp_ready(i)) begin
                    n_err++; $display("FAIL random code_ready[%0d]: got %b exp %b at %0t", i, cr[i], exp_ready(i), $time);
                end
                n_vec++;
                if (bz[i] !== exp_busy(i)) begin
                    n_err++; $display("FAIL random busy[%0d]: got %b exp %b at %0t", i, bz[i], exp_busy(i), $time);
                end
                n_vec++;
                if (dn[i] !== m_done[i]) begin
                    n_err++; $display("FAIL random done[%0d]: got %b exp %b at %0t", i, dn[i], m_done[i], $time);
                end
                n_vec++;
                if ($countones(dv[i] ^ POL) > 1) begin
                    n_err++; $display("FAIL random onehot[%0d]: got %h exp at most one line", i, dv[i]);
                end
            end
            next_cycle();
        end
    endtask

    // ---------------- sequence / final report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_gap();
        test_mid_reset();
        test_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
